bus_initiator: RTL
==================

BUS_INITIATOR -- requirements
Module: bus_initiator

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, width of the request address and addr_bus.
REQ-002 Parameter DATA_WIDTH, default 32, width of the write data, read data and data_bus.
REQ-003 The module SHALL have one clock and an asynchronous active-low reset:
  clk  input  1  rising-edge clock.
  rst  input  1  asynchronous reset, active-low.
REQ-004 The module SHALL have these other ports:
  req_valid  input  1  host requests a bus access.
  req_write  input  1  1 = write, 0 = read.
  req_addr  input  ADDR_WIDTH  access address.
  req_wdata  input  DATA_WIDTH  write data.
  req_ready  output  1  initiator can accept a request this cycle.
  resp_valid  output  1  one-cycle pulse, access finished.
  resp_rdata  output  DATA_WIDTH  captured read data.
  resp_error  output  1  access ended by timeout.
  addr_bus  output  ADDR_WIDTH  bus address, high-Z when not owning the bus.
  data_bus  inout  DATA_WIDTH  bus data, driven only during a write access.
  rd_bus  output  1  read strobe.
  wr_bus  output  1  write strobe.
  fc_bus  input  1  function complete, from the responder or the watchdog.
  access_timeout  input  1  watchdog timeout flag.

Function
REQ-005 The FSM SHALL have three states: IDLE, ACCESS and DONE.
REQ-006 In IDLE, req_ready SHALL be 1; in every other state it SHALL be 0.
REQ-007 In IDLE with req_valid=1 at a clock edge, the module SHALL latch req_write, req_addr and req_wdata, then go to ACCESS.
REQ-008 In ACCESS:
  - rd_bus SHALL equal the inverse of the latched write bit.
  - wr_bus SHALL equal the latched write bit.
  - addr_bus SHALL drive the latched address.
  - data_bus SHALL drive the latched wdata only for a write; it SHALL be high-Z for a read.
REQ-009 Outside ACCESS:
  - rd_bus and wr_bus SHALL be 0.
  - addr_bus and data_bus SHALL be high-Z.
REQ-010 Strobes SHALL rise one cycle after the accepting edge, so request-to-strobe latency is 1 cycle.
REQ-011 In ACCESS with fc_bus=1 sampled at a clock edge:
  - For a read, capture data_bus into resp_rdata; for a write, leave resp_rdata unchanged.
  - Capture access_timeout into resp_error.
  - Go to DONE.
REQ-012 Strobes SHALL remain asserted for as long as fc_bus=0; there is no internal timeout, and termination relies on the watchdog.
REQ-013 resp_valid SHALL be 1 for exactly the first cycle in DONE.
REQ-014 DONE SHALL return to IDLE at the first edge where fc_bus=0, which may be the edge that ends the resp_valid cycle.
REQ-015 While fc_bus stays 1 in DONE (responder or watchdog still holding it), the module SHALL remain in DONE and resp_valid SHALL be 0.
REQ-016 A req_valid asserted outside IDLE SHALL be ignored; it is not queued.
REQ-017 If fc_bus=1 is already present when the module enters ACCESS, the access SHALL complete at the first ACCESS edge, giving a strobe width of 1 cycle.
REQ-018 access_timeout SHALL be sampled only at the completing edge; its value at any other time SHALL be ignored.
REQ-019 resp_rdata and resp_error SHALL hold their values until the next access completes.
REQ-020 Back-to-back transactions: minimum issue interval SHALL be 3 cycles (accept edge, completing ACCESS edge, DONE edge with fc_bus=0).

Reset
REQ-021 While rst=0, asynchronously, the module SHALL:
  - set the state to IDLE;
  - set rd_bus, wr_bus, resp_valid and resp_error to 0;
  - set resp_rdata and the latched request to 0;
  - float addr_bus and data_bus.
REQ-022 Reset asserted mid-access SHALL drop the strobes immediately, without waiting for fc_bus, and SHALL NOT produce a response.
REQ-023 After rst rises, req_ready SHALL be 1 from the first cycle.

Verification
REQ-024 Read, fc after 3 cycles: read of 0x0000_0010; responder drives data_bus=0xDEAD_BEEF with fc_bus=1 on the 3rd ACCESS cycle -> rd_bus high 3 cycles; resp_valid pulse; resp_rdata=0xDEAD_BEEF; resp_error=0.
REQ-025 Write: write 0x1234_5678 to 0x0000_0020; fc_bus=1 on the 1st ACCESS cycle -> wr_bus high 1 cycle; data_bus=0x1234_5678 while wr_bus=1, high-Z otherwise; resp_error=0.
REQ-026 Timeout: read with no responder; watchdog model asserts fc_bus=1 and access_timeout=1 after 1000 cycles and holds them until the strobe drops -> resp_valid pulse; resp_error=1; return to IDLE one cycle after fc_bus falls.
REQ-027 fc_bus held in DONE: fc_bus stays 1 for 4 cycles after completion -> resp_valid 1 cycle only; req_ready=0 until fc_bus=0.
REQ-028 Reset mid-access: rst=0 on the 2nd ACCESS cycle, asynchronously relative to clk -> rd_bus=0 immediately; no resp_valid; req_ready=1 after rst=1.
REQ-029 Ignored request: req_valid held 1 continuously across two transactions -> exactly one accept per IDLE visit; issue interval ≥3 cycles.

Source files
------------

// File: rtl/bus_initiator.sv
// Bus initiator: turns one host request into a strobed read or write access on a shared tri-state bus.
// Latency: strobe rises one cycle after accept; resp_valid pulses one cycle after the fc_bus completing edge.
// Backpressure: req_ready only in IDLE; requests presented in any other state are dropped, never queued.
module bus_initiator #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  req_ready,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_error,
  output logic [ADDR_WIDTH-1:0] addr_bus,
  inout  wire  [DATA_WIDTH-1:0] data_bus,
  output logic                  rd_bus,
  output logic                  wr_bus,
  input  logic                  fc_bus,
  input  logic                  access_timeout
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic                    wr_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    drive_addr;
  logic                    drive_data;
  logic                    accept;
  logic                    complete;

  assign accept   = (state == IDLE) && req_valid;
  assign complete = (state == ACCESS) && fc_bus;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = ACCESS;
      ACCESS:  if (fc_bus)    state_nxt = DONE;
      // fc_bus may still be held by the responder or watchdog after completion
      DONE:    if (!fc_bus)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes decode straight from state so an async reset drops them at once
  always_comb begin
    req_ready  = 1'b0;
    rd_bus     = 1'b0;
    wr_bus     = 1'b0;
    drive_addr = 1'b0;
    drive_data = 1'b0;
    case (state)
      IDLE: req_ready = 1'b1;
      ACCESS: begin
        rd_bus     = ~wr_q;
        wr_bus     = wr_q;
        drive_addr = 1'b1;
        drive_data = wr_q;
      end
      default: ;
    endcase
  end

  assign addr_bus = drive_addr ? addr_q : {ADDR_WIDTH{1'bz}};
  assign data_bus = drive_data ? wdata_q : {DATA_WIDTH{1'bz}};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_error <= 1'b0;
    end else begin
      resp_valid <= complete;
      if (accept) begin
        wr_q    <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (complete) begin
        if (!wr_q) resp_rdata <= data_bus;
        resp_error <= access_timeout;
      end
    end
  end

endmodule
